// File: rtl/fixedpoint_pkg.sv
// -----------------------------------------------------------------------------
// fixedpoint_pkg
// Shared definitions for the fixed-point Horner polynomial evaluator:
//   - default integer/fraction widths of the signed Q(WI).(WF) format
//   - FSM state encoding of the evaluator
//   - saturation bound helpers for a given word width (used when the block is
//     built with HORNER_SATURATE_EN defined)
// -----------------------------------------------------------------------------
package fixedpoint_pkg;

    localparam int DEFAULT_WI = 4;
    localparam int DEFAULT_WF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } horner_state_t;

    // Largest positive two's-complement value of a w-bit word, 2^(w-1)-1,
    // returned right-aligned in 64 bits; callers size-cast to their width.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word, -2^(w-1); the low
    // w bits of the result are 1 followed by zeros.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/fixedpoint_mul_rescale.sv
// -----------------------------------------------------------------------------
// fixedpoint_mul_rescale
// Combinational signed fixed-point multiply with rescale back to Q(WI).(WF).
// The full 2W-bit product is shifted right arithmetically by WF (floor, i.e.
// truncation toward minus infinity) and the low W bits are kept.
// Optional macro HORNER_SATURATE_EN: on overflow the result clamps to the
// format MAX/MIN chosen by the sign of the true product; otherwise it wraps.
// Ports:
//   a, b  in   W   signed operands
//   p     out  W   rescaled product (wrapped or clamped)
//   ov    out  1   rescaled product does not fit in W bits
// -----------------------------------------------------------------------------
module fixedpoint_mul_rescale
    import fixedpoint_pkg::*;
#(
    parameter int WI = DEFAULT_WI,
    parameter int WF = DEFAULT_WF,
    localparam int W = WI + WF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         ov
);

`ifdef HORNER_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));
`endif

    logic [2*W-1:0] full_s;
    logic [2*W-1:0] shifted_s;
    logic [W-1:0]   kept_s;
    logic [W-1:0]   upper_s;

    // Sign-extend both operands to 2W bits; the low 2W bits of the product
    // are then the exact signed product.
    always_comb begin
        full_s    = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        shifted_s = $signed(full_s) >>> WF;
        kept_s    = shifted_s[W-1:0];
        upper_s   = shifted_s[2*W-1:W];
        // Result fits only if every discarded bit copies the kept sign bit.
        ov        = (upper_s != {W{kept_s[W-1]}});
`ifdef HORNER_SATURATE_EN
        if (ov) begin
            p = full_s[2*W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            p = kept_s;
        end
`else
        p = kept_s;
`endif
    end

endmodule

// File: rtl/fixedpoint_horner_eval.sv
// -----------------------------------------------------------------------------
// fixedpoint_horner_eval
// Sequential fixed-point polynomial evaluator y = c0 + c1*x + ... + cN*x^N by
// Horner's method: acc = cN, then for k = N-1 downto 0: acc = acc*x + ck.
// Each coefficient costs one MUL cycle and one ADD cycle; one evaluation is in
// flight at a time. Coefficients live in a register file writable in IDLE.
// Optional macro HORNER_SATURATE_EN: multiply and add steps clamp to MAX/MIN
// on overflow instead of wrapping; the sticky overflow flag is set either way.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready/x_in          input handshake and operand x
//   coef_we/coef_addr/coef_data     coefficient write port (IDLE only)
//   out_valid/out_ready/y_out/ov_out output handshake, result, sticky overflow
// -----------------------------------------------------------------------------
module fixedpoint_horner_eval
    import fixedpoint_pkg::*;
#(
    parameter int WI    = DEFAULT_WI,
    parameter int WF    = DEFAULT_WF,
    parameter int ORDER = 3,
    localparam int W    = WI + WF,
    localparam int AW   = $clog2(ORDER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y_out,
    output logic          ov_out
);

`ifdef HORNER_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));
`endif

    horner_state_t state_q, state_d;
    logic [W-1:0]  coef_q [0:ORDER];
    logic [W-1:0]  coef_d [0:ORDER];
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  prod_q, prod_d;
    logic [AW-1:0] k_q, k_d;
    logic          ov_q, ov_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  y_out_q, y_out_d;
    logic          ov_out_q, ov_out_d;

    logic [W-1:0]  mul_p_s;
    logic          mul_ov_s;
    logic [W:0]    sum_s;
    logic [W-1:0]  add_res_s;
    logic          add_ov_s;

    fixedpoint_mul_rescale #(
        .WI (WI),
        .WF (WF)
    ) u_mul (
        .a  (acc_q),
        .b  (x_q),
        .p  (mul_p_s),
        .ov (mul_ov_s)
    );

    // Add step: one extra bit so that disagreeing top bits flag a true
    // signed overflow; sum_s[W] is the sign of the exact result.
    always_comb begin
        sum_s    = {prod_q[W-1], prod_q} + {coef_q[k_q][W-1], coef_q[k_q]};
        add_ov_s = (sum_s[W] != sum_s[W-1]);
`ifdef HORNER_SATURATE_EN
        if (add_ov_s) begin
            add_res_s = sum_s[W] ? SAT_MIN : SAT_MAX;
        end else begin
            add_res_s = sum_s[W-1:0];
        end
`else
        add_res_s = sum_s[W-1:0];
`endif
    end

    // Next-state and next-output logic of the evaluator FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        k_d         = k_q;
        ov_d        = ov_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        y_out_d     = y_out_q;
        ov_out_d    = ov_out_q;
        for (int i = 0; i <= ORDER; i++) begin
            coef_d[i] = coef_q[i];
        end

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                // Addresses above ORDER match no entry and are dropped.
                for (int i = 0; i <= ORDER; i++) begin
                    coef_d[i] = (coef_we && (coef_addr == AW'(i))) ? coef_data : coef_q[i];
                end
                // Start from coef_d so a same-cycle write to cN is seen.
                if (in_valid && in_ready_q) begin
                    x_d        = x_in;
                    acc_d      = coef_d[ORDER];
                    k_d        = AW'(ORDER - 1);
                    ov_d       = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
                end else begin
                    state_d    = IDLE;
                end
            end
            MUL: begin
                prod_d  = mul_p_s;
                ov_d    = ov_q | mul_ov_s;
                state_d = ADD;
            end
            ADD: begin
                acc_d = add_res_s;
                ov_d  = ov_q | add_ov_s;
                if (k_q == {AW{1'b0}}) begin
                    out_valid_d = 1'b1;
                    y_out_d     = add_res_s;
                    ov_out_d    = ov_q | add_ov_s;
                    state_d     = DONE;
                end else begin
                    k_d     = k_q - AW'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= {W{1'b0}};
            acc_q       <= {W{1'b0}};
            prod_q      <= {W{1'b0}};
            k_q         <= {AW{1'b0}};
            ov_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_out_q     <= {W{1'b0}};
            ov_out_q    <= 1'b0;
            for (int i = 0; i <= ORDER; i++) begin
                coef_q[i] <= {W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            k_q         <= k_d;
            ov_q        <= ov_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_out_q     <= y_out_d;
            ov_out_q    <= ov_out_d;
            for (int i = 0; i <= ORDER; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_out_q;
    assign ov_out    = ov_out_q;

endmodule

// File: tb/tb_fixedpoint_horner_eval.sv
// -----------------------------------------------------------------------------
// tb_fixedpoint_horner_eval
// Directed bench for fixedpoint_horner_eval (WI=4, WF=12, ORDER=3) with
// hand-computed expected results. Honours HORNER_SATURATE_EN for the
// overflow vector.
// -----------------------------------------------------------------------------
module tb_fixedpoint_horner_eval;

    localparam int WI    = 4;
    localparam int WF    = 12;
    localparam int ORDER = 3;
    localparam int W     = WI + WF;
    localparam int AW    = $clog2(ORDER + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x_in;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y_out;
    logic          ov_out;

    int checks   = 0;
    int failures = 0;

    fixedpoint_horner_eval #(
        .WI    (WI),
        .WF    (WF),
        .ORDER (ORDER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .ov_out    (ov_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [AW-1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        #1;
        coef_we   = 1'b0;
    endtask

    task automatic load_coefs(input logic [W-1:0] c0, input logic [W-1:0] c1,
                              input logic [W-1:0] c2, input logic [W-1:0] c3);
        write_coef(2'd0, c0);
        write_coef(2'd1, c1);
        write_coef(2'd2, c2);
        write_coef(2'd3, c3);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s_ready", tag), {31'd0, in_ready}, 32'd1);
    endtask

    // One evaluation. same_wr: coefficient write in the accepting cycle.
    // mul_wr: write c0=0x7777 during the first MUL cycle (must be ignored).
    // hold: cycles of out_ready=0 stall checked in DONE.
    task automatic run_eval(input string tag, input logic [W-1:0] x,
                            input logic [W-1:0] y_exp, input logic ov_exp,
                            input logic same_wr, input logic [AW-1:0] wr_addr,
                            input logic [W-1:0] wr_data, input logic mul_wr,
                            input int hold);
        int lat;
        wait_ready(tag);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        if (same_wr) begin
            coef_we   = 1'b1;
            coef_addr = wr_addr;
            coef_data = wr_data;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat      = 0;
        if (mul_wr) begin
            chk($sformatf("%s_busy_ready", tag), {31'd0, in_ready}, 32'd0);
            coef_we   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 16'h7777;
            @(posedge clk);
            #1;
            coef_we   = 1'b0;
            lat       = 1;
        end
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s_lat", tag), lat, 2 * ORDER);
        chk($sformatf("%s_y", tag), {16'd0, y_out}, {16'd0, y_exp});
        chk($sformatf("%s_ov", tag), {31'd0, ov_out}, {31'd0, ov_exp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_hold%0d_v", tag, i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("%s_hold%0d_y", tag, i), {16'd0, y_out}, {16'd0, y_exp});
            chk($sformatf("%s_hold%0d_rdy", tag, i), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("%s_drain_v", tag), {31'd0, out_valid}, 32'd0);
        chk($sformatf("%s_drain_rdy", tag), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ovf_exp;
`ifdef HORNER_SATURATE_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'h9000;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = 16'h0000;
        coef_we   = 1'b0;
        coef_addr = 2'd0;
        coef_data = 16'h0000;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", {16'd0, y_out}, 32'd0);
        chk("rst_ov", {31'd0, ov_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Exact evaluation, x = 0.5: 1 + 0.25 + 0.0625 + 0.015625 = 1.328125.
        load_coefs(16'h1000, 16'h0800, 16'h0400, 16'h0200);
        run_eval("exact", 16'h0800, 16'h1540, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 0);
        // Same vector with a write during MUL (ignored) and a 5-cycle stall.
        run_eval("busy", 16'h0800, 16'h1540, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 5);
        // Negative x = -1.0: 1 - 0.5 + 0.25 - 0.125 = 0.625.
        run_eval("neg", 16'hF000, 16'h0A00, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 0);
        // Write c0 = 2.0 in the accepting cycle; x = 0 gives y = c0.
        run_eval("samewr", 16'h0000, 16'h2000, 1'b0, 1'b1, 2'd0, 16'h2000, 1'b0, 0);

        // Overflow: coefs all 7.0, x = 2.0. Wrap path: 14->-2, +7=5,
        // 10->-6, +7=1, 2, +7=9 -> 0x9000.
        load_coefs(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        run_eval("ovf", 16'h2000, ovf_exp, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 0);

        // Truncation: c3 = -2^-12, x = 2^-12; each product floors to -2^-12.
        load_coefs(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        run_eval("trunc", 16'h0001, 16'hFFFF, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 0);

        // Reset during ADD discards the evaluation and clears coefficients.
        load_coefs(16'h1000, 16'h0800, 16'h0400, 16'h0200);
        wait_ready("midrst");
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'h0800;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
        run_eval("cleared", 16'h1000, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
